// File: rtl/timer555_pkg.sv
// timer555_pkg: shared states, result record and default sizes for timer555 capture logic
package timer555_pkg;
  localparam int CNT_W_DEF = 24;
  localparam int TIMEOUT_DEF = 2**20;
  typedef enum logic [1:0] {IDLE, HIGH, LOW} cap_state_t;
  typedef struct packed {
    logic [CNT_W_DEF-1:0] high;
    logic [CNT_W_DEF-1:0] low;
    logic [CNT_W_DEF-1:0] period;
    logic                 sat;
  } cap_result_t;
endpackage

// File: rtl/pulse_sync.sv
// pulse_sync: synchronizes an async level and emits registered one-cycle rise/fall strobes
module pulse_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pulse_in,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic lvl_q, lvl_d, rise_q, rise_d, fall_q, fall_d;
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pulse_in};
    lvl_d  = sync_q[SYNC_STAGES-1];
    rise_d = lvl_d & ~lvl_q;
    fall_d = ~lvl_d & lvl_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      lvl_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      lvl_q  <= lvl_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end
  assign level = lvl_q;
  assign rise  = rise_q;
  assign fall  = fall_q;
endmodule

// File: rtl/timer555_capture.sv
// timer555_capture: measures high/low/period of the timer555 output in clock counts
module timer555_capture
  import timer555_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             pulse_in,
  input  logic             res_ready,
  output logic             res_valid,
  output logic [CNT_W-1:0] high_cycles,
  output logic [CNT_W-1:0] low_cycles,
  output logic [CNT_W-1:0] period_cycles,
  output logic             sat,
  output logic             overrun,
  output logic             stuck
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] MAX = '1;
  cap_state_t state_q, state_d;
  logic [CNT_W-1:0] hi_q, hi_d, lo_q, lo_d, rhi_q, rhi_d, rlo_q, rlo_d, rper_q, rper_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic msat_q, msat_d, rsat_q, rsat_d, vld_q, vld_d, ovr_q, ovr_d, stuck_q, stuck_d;
  logic lvl, rise, fall, edge_hit, tmo, done, load;
  logic [CNT_W:0] sum;

  pulse_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk), .rst(rst), .pulse_in(pulse_in), .level(lvl), .rise(rise), .fall(fall)
  );

  // The edge timer stands in for the phase counter so a narrow CNT_W cannot hide a timeout
  always_comb begin
    sum      = {1'b0, hi_q} + {1'b0, lo_q};
    edge_hit = rise | (fall & (state_q == HIGH));
    tmo      = en & ~edge_hit & (tmr_q == TW'(TIMEOUT));
    done     = en & rise & (state_q == LOW);
    load     = done & (~vld_q | res_ready);
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    msat_d   = msat_q;
    if (!en) begin
      state_d = IDLE;
      hi_d    = '0;
      lo_d    = '0;
      msat_d  = 1'b0;
    end else if (rise) begin
      state_d = HIGH;
      hi_d    = CNT_W'(1);
      lo_d    = '0;
      msat_d  = 1'b0;
    end else if (tmo) begin
      state_d = IDLE;
    end else if (state_q == HIGH && fall) begin
      state_d = LOW;
      lo_d    = CNT_W'(1);
    end else if (state_q == HIGH && lvl) begin
      hi_d   = (hi_q == MAX) ? hi_q : hi_q + 1'b1;
      msat_d = msat_q | (hi_q == MAX);
    end else if (state_q == LOW && !lvl) begin
      lo_d   = (lo_q == MAX) ? lo_q : lo_q + 1'b1;
      msat_d = msat_q | (lo_q == MAX);
    end
    tmr_d   = !en ? '0 : edge_hit ? TW'(1) : (tmr_q == TW'(TIMEOUT)) ? tmr_q : tmr_q + TW'(1);
    stuck_d = rise ? 1'b0 : tmo ? 1'b1 : stuck_q;
    rhi_d   = load ? hi_q : rhi_q;
    rlo_d   = load ? lo_q : rlo_q;
    rper_d  = load ? (sum[CNT_W] ? MAX : sum[CNT_W-1:0]) : rper_q;
    rsat_d  = load ? (msat_q | sum[CNT_W]) : rsat_q;
    vld_d   = load | (vld_q & ~res_ready);
    ovr_d   = (done & vld_q & ~res_ready) | (ovr_q & ~(vld_q & res_ready));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      msat_q  <= 1'b0;
      tmr_q   <= '0;
      stuck_q <= 1'b0;
      rhi_q   <= '0;
      rlo_q   <= '0;
      rper_q  <= '0;
      rsat_q  <= 1'b0;
      vld_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      msat_q  <= msat_d;
      tmr_q   <= tmr_d;
      stuck_q <= stuck_d;
      rhi_q   <= rhi_d;
      rlo_q   <= rlo_d;
      rper_q  <= rper_d;
      rsat_q  <= rsat_d;
      vld_q   <= vld_d;
      ovr_q   <= ovr_d;
    end
  end

  assign res_valid     = vld_q;
  assign high_cycles   = rhi_q;
  assign low_cycles    = rlo_q;
  assign period_cycles = rper_q;
  assign sat           = rsat_q;
  assign overrun       = ovr_q;
  assign stuck         = stuck_q;
endmodule
